// File: rtl/cluster_sched_pkg.sv
// Shared types for the systolic cluster job scheduler.
// Job bundle, FSM states and drain length helper.
package cluster_sched_pkg;

  localparam int SCHED_K_BITS   = 8;
  localparam int SCHED_TAG_BITS = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALLOC,
    S_CLEAR,
    S_LOAD,
    S_STREAM,
    S_DRAIN,
    S_WAIT_RDY,
    S_REPORT
  } sched_state_t;

  // Field widths track the scheduler's default K_BITS/TAG_BITS.
  typedef struct packed {
    logic [SCHED_K_BITS-1:0]   k_len;
    logic [SCHED_TAG_BITS-1:0] tag;
  } sched_job_t;

  // Cycles for the last partial sums to leave a square array.
  function automatic int drain_cycles(input int array_size);
    return 2 * array_size - 2;
  endfunction

endpackage

// File: rtl/sched_job_fifo.sv
// Synchronous job queue with full/empty flags.
// Push is dropped when full, pop is ignored when empty.
module sched_job_fifo
  import cluster_sched_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = sched_job_t
)(
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     pop_data,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  T mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Read/write pointers; extra MSB tells full from empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop && !empty)
        rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/systolic_cluster_scheduler.sv
// Job scheduler and sequencer for the systolic array cluster.
// Queues jobs, allocates arrays round-robin, sequences each job.
module systolic_cluster_scheduler
  import cluster_sched_pkg::*;
#(
  parameter int NUM_ARRAYS     = 8,
  parameter int ARRAY_SIZE     = 8,
  parameter int K_BITS         = 8,
  parameter int TAG_BITS       = 4,
  parameter int JOB_FIFO_DEPTH = 4
)(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          job_valid,
  output logic                          job_ready,
  input  logic [K_BITS-1:0]             job_k_len,
  input  logic [TAG_BITS-1:0]           job_tag,
  input  logic                          feed_valid,
  output logic                          feed_req,
  output logic                          feed_zero,
  output logic                          cl_enable,
  output logic [$clog2(NUM_ARRAYS)-1:0] cl_array_select,
  output logic                          cl_clear_acc,
  output logic                          cl_load_weights,
  output logic                          cl_compute_enable,
  output logic                          cl_broadcast_mode,
  input  logic                          cl_ready,
  output logic                          done_valid,
  input  logic                          done_ready,
  output logic [$clog2(NUM_ARRAYS)-1:0] done_array,
  output logic [TAG_BITS-1:0]           done_tag,
  input  logic                          release_valid,
  input  logic [$clog2(NUM_ARRAYS)-1:0] release_array,
  output logic [NUM_ARRAYS-1:0]         busy_mask
);

  localparam int AW      = $clog2(NUM_ARRAYS);
  localparam int DRAIN_N = drain_cycles(ARRAY_SIZE);
  localparam int DW      = $clog2(DRAIN_N + 1);

  localparam logic [DW-1:0]     DRAIN_LAST = DW'(DRAIN_N - 1);
  localparam logic [DW-1:0]     DRAIN_ONE  = DW'(1);
  localparam logic [K_BITS-1:0] K_ONE      = K_BITS'(1);

  sched_state_t state;
  sched_state_t state_next;

  sched_job_t job_in;
  sched_job_t head_job;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_pop;

  logic [K_BITS-1:0]     k_len_q;
  logic [K_BITS-1:0]     beat_cnt;
  logic [TAG_BITS-1:0]   tag_q;
  logic [DW-1:0]         drain_cnt;
  logic [AW-1:0]         sel_q;
  logic [AW-1:0]         rr_ptr;
  logic [AW-1:0]         pick;
  logic [AW-1:0]         cand;
  logic [AW-1:0]         done_array_q;
  logic [TAG_BITS-1:0]   done_tag_q;
  logic [NUM_ARRAYS-1:0] busy_q;
  logic [NUM_ARRAYS-1:0] rel_mask;
  logic [NUM_ARRAYS-1:0] avail_busy;
  logic                  found;
  logic                  seq_active;
  logic                  alloc_fire;

  assign job_in = '{
    k_len: SCHED_K_BITS'(job_k_len),
    tag:   SCHED_TAG_BITS'(job_tag)
  };

  assign job_ready = !fifo_full;
  assign fifo_pop  = (state == S_IDLE) && !fifo_empty;

  sched_job_fifo #(
    .DEPTH (JOB_FIFO_DEPTH),
    .T     (sched_job_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (job_valid),
    .push_data (job_in),
    .pop       (fifo_pop),
    .pop_data  (head_job),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Host release; the array under sequencing stays pinned.
  always_comb begin
    rel_mask   = '0;
    seq_active = state inside {S_CLEAR, S_LOAD, S_STREAM,
                               S_DRAIN, S_WAIT_RDY, S_REPORT};
    if (release_valid && busy_q[release_array] &&
        !(seq_active && release_array == sel_q))
      rel_mask[release_array] = 1'b1;
  end

  assign avail_busy = busy_q & ~rel_mask;

  // Round-robin free search starting after the last grant.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 1; i <= NUM_ARRAYS; i++) begin
      cand = rr_ptr + AW'(i);
      if (!found && !avail_busy[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign alloc_fire = (state == S_ALLOC) && found;

  // Next state and state-decoded cluster controls.
  always_comb begin
    state_next        = state;
    feed_req          = 1'b0;
    feed_zero         = 1'b0;
    cl_enable         = state != S_IDLE;
    cl_clear_acc      = 1'b0;
    cl_load_weights   = 1'b0;
    cl_compute_enable = 1'b0;
    done_valid        = 1'b0;
    unique case (state)
      S_IDLE:
        if (!fifo_empty) state_next = S_ALLOC;
      S_ALLOC:
        if (found) state_next = S_CLEAR;
      S_CLEAR: begin
        cl_clear_acc = 1'b1;
        state_next   = S_LOAD;
      end
      S_LOAD: begin
        feed_req        = 1'b1;
        cl_load_weights = feed_valid;
        if (feed_valid)
          state_next = (k_len_q == '0) ? S_DRAIN : S_STREAM;
      end
      S_STREAM: begin
        feed_req          = 1'b1;
        cl_compute_enable = feed_valid;
        if (feed_valid && beat_cnt == k_len_q - K_ONE)
          state_next = S_DRAIN;
      end
      S_DRAIN: begin
        feed_zero         = 1'b1;
        cl_compute_enable = 1'b1;
        if (drain_cnt == DRAIN_LAST) state_next = S_WAIT_RDY;
      end
      S_WAIT_RDY:
        if (cl_ready) state_next = S_REPORT;
      S_REPORT: begin
        done_valid = 1'b1;
        if (done_ready) state_next = S_IDLE;
      end
      default:
        state_next = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Job latch, allocator, counters and completion record.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q       <= '0;
      rr_ptr       <= AW'(NUM_ARRAYS - 1);
      sel_q        <= '0;
      k_len_q      <= '0;
      tag_q        <= '0;
      beat_cnt     <= '0;
      drain_cnt    <= '0;
      done_array_q <= '0;
      done_tag_q   <= '0;
    end else begin
      busy_q <= avail_busy |
                (alloc_fire ? (NUM_ARRAYS'(1) << pick) : '0);
      if (fifo_pop) begin
        k_len_q <= K_BITS'(head_job.k_len);
        tag_q   <= TAG_BITS'(head_job.tag);
      end
      if (alloc_fire) begin
        sel_q  <= pick;
        rr_ptr <= pick;
      end
      if (state != S_STREAM) beat_cnt <= '0;
      else if (feed_valid)   beat_cnt <= beat_cnt + K_ONE;
      if (state == S_DRAIN) drain_cnt <= drain_cnt + DRAIN_ONE;
      else                  drain_cnt <= '0;
      if (state == S_WAIT_RDY && cl_ready) begin
        done_array_q <= sel_q;
        done_tag_q   <= tag_q;
      end
    end
  end

  assign cl_array_select   = sel_q;
  assign cl_broadcast_mode = 1'b0;
  assign done_array        = done_array_q;
  assign done_tag          = done_tag_q;
  assign busy_mask         = busy_q;

endmodule

// File: tb/tb_systolic_cluster_scheduler.sv
// Scoreboard bench for systolic_cluster_scheduler.
// Expected completions are queued at push time, popped on done.
module tb_systolic_cluster_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       job_valid;
  logic       job_ready;
  logic [7:0] job_k_len;
  logic [3:0] job_tag;
  logic       feed_valid;
  logic       feed_req;
  logic       feed_zero;
  logic       cl_enable;
  logic [2:0] cl_array_select;
  logic       cl_clear_acc;
  logic       cl_load_weights;
  logic       cl_compute_enable;
  logic       cl_broadcast_mode;
  logic       cl_ready;
  logic       done_valid;
  logic       done_ready;
  logic [2:0] done_array;
  logic [3:0] done_tag;
  logic       release_valid;
  logic [2:0] release_array;
  logic [7:0] busy_mask;

  typedef struct packed {
    logic [2:0] arr;
    logic [3:0] tag;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  systolic_cluster_scheduler dut (
    .clk               (clk),
    .reset             (reset),
    .job_valid         (job_valid),
    .job_ready         (job_ready),
    .job_k_len         (job_k_len),
    .job_tag           (job_tag),
    .feed_valid        (feed_valid),
    .feed_req          (feed_req),
    .feed_zero         (feed_zero),
    .cl_enable         (cl_enable),
    .cl_array_select   (cl_array_select),
    .cl_clear_acc      (cl_clear_acc),
    .cl_load_weights   (cl_load_weights),
    .cl_compute_enable (cl_compute_enable),
    .cl_broadcast_mode (cl_broadcast_mode),
    .cl_ready          (cl_ready),
    .done_valid        (done_valid),
    .done_ready        (done_ready),
    .done_array        (done_array),
    .done_tag          (done_tag),
    .release_valid     (release_valid),
    .release_array     (release_array),
    .busy_mask         (busy_mask)
  );

  task automatic do_reset();
    @(negedge clk);
    reset         = 1'b1;
    job_valid     = 1'b0;
    job_k_len     = '0;
    job_tag       = '0;
    feed_valid    = 1'b1;
    cl_ready      = 1'b1;
    done_ready    = 1'b0;
    release_valid = 1'b0;
    release_array = '0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    sb.delete();
  endtask

  // Push one job and queue its expected completion.
  task automatic push_job(input int k, input int tag,
                          input logic [2:0] arr);
    int w = 0;
    @(negedge clk);
    while (!job_ready && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (!job_ready) begin
      checks++;
      failures++;
      $display("FAIL push_timeout job_ready=%b want 1", job_ready);
    end else begin
      job_valid = 1'b1;
      job_k_len = 8'(k);
      job_tag   = 4'(tag);
      sb.push_back('{arr: arr, tag: 4'(tag)});
      @(posedge clk);
      #1 job_valid = 1'b0;
    end
  endtask

  // n = cycle index of first done_valid, -1 if budget expires.
  task automatic wait_done(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (done_valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic ack();
    done_ready = 1'b1;
    @(posedge clk);
    #1 done_ready = 1'b0;
  endtask

  task automatic release_arr(input logic [2:0] a);
    @(negedge clk);
    release_valid = 1'b1;
    release_array = a;
    @(posedge clk);
    #1 release_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (job_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_job_ready got %b want 1", job_ready);
    end
    checks++;
    if (busy_mask !== 8'h00) begin
      failures++;
      $display("FAIL rst_busy got %h want 00", busy_mask);
    end
    checks++;
    if ({cl_enable, cl_clear_acc, cl_load_weights, cl_compute_enable,
         cl_broadcast_mode, feed_req, feed_zero, done_valid} !== 8'h00) begin
      failures++;
      $display("FAIL rst_ctrl got %b want 0", {cl_enable, cl_clear_acc,
               cl_load_weights, cl_compute_enable, feed_req, done_valid});
    end
    checks++;
    if ({cl_array_select, done_array, done_tag} !== 10'h000) begin
      failures++;
      $display("FAIL rst_done got %0d/%0d/%h want 0/0/0",
               cl_array_select, done_array, done_tag);
    end
  endtask

  task automatic test_single();
    int clr_n = 0, clr_cnt = 0, ld_n = 0, ld_cnt = 0;
    int beats = 0, drains = 0, done_n = -1;
    exp_t e;
    do_reset();
    push_job(4, 5, 3'd0);
    for (int n = 1; n <= 60 && done_n < 0; n++) begin
      @(negedge clk);
      if (cl_clear_acc) begin
        clr_cnt++;
        if (clr_n == 0) clr_n = n;
      end
      if (cl_load_weights) begin
        ld_cnt++;
        if (ld_n == 0) ld_n = n;
      end
      if (cl_compute_enable && !feed_zero) beats++;
      if (cl_compute_enable && feed_zero) drains++;
      if (done_valid) done_n = n;
    end
    checks++;
    if (clr_n !== 3 || clr_cnt !== 1 || ld_n !== 4 || ld_cnt !== 1) begin
      failures++;
      $display("FAIL single_clr_load got clr@%0d x%0d load@%0d x%0d want 3 x1 4 x1",
               clr_n, clr_cnt, ld_n, ld_cnt);
    end
    checks++;
    if (beats !== 4 || drains !== 14) begin
      failures++;
      $display("FAIL single_beats got %0d/%0d want 4/14", beats, drains);
    end
    checks++;
    if (done_n !== 24) begin
      failures++;
      $display("FAIL single_latency got %0d want 24", done_n);
    end
    if (done_n > 0) begin
      e = sb.pop_front();
      checks++;
      if ({done_array, done_tag} !== {e.arr, e.tag}) begin
        failures++;
        $display("FAIL single_done got %0d/%h want %0d/%h",
                 done_array, done_tag, e.arr, e.tag);
      end
    end
    checks++;
    if (busy_mask !== 8'h01) begin
      failures++;
      $display("FAIL single_busy got %h want 01", busy_mask);
    end
    ack();
  endtask

  task automatic test_back_to_back();
    int n, clr;
    exp_t e;
    do_reset();
    fork
      begin
        // Ninth job lands on array 3, freed below while it waits.
        for (int i = 0; i < 9; i++)
          push_job(1, i, (i < 8) ? 3'(i) : 3'd3);
      end
      begin
        for (int j = 0; j < 8; j++) begin
          wait_done(300, n);
          checks++;
          if (n < 0) begin
            failures++;
            $display("FAIL b2b_timeout job %0d", j);
          end else begin
            e = sb.pop_front();
            if ({done_array, done_tag} !== {e.arr, e.tag}) begin
              failures++;
              $display("FAIL b2b_done got %0d/%h want %0d/%h",
                       done_array, done_tag, e.arr, e.tag);
            end
            ack();
          end
        end
      end
    join
    clr = 0;
    repeat (6) begin
      @(negedge clk);
      if (cl_clear_acc) clr++;
    end
    checks++;
    if (clr !== 0 || cl_enable !== 1'b1) begin
      failures++;
      $display("FAIL b2b_stall got clears=%0d en=%b want 0 1", clr, cl_enable);
    end
    checks++;
    if (busy_mask !== 8'hFF) begin
      failures++;
      $display("FAIL b2b_busy got %h want ff", busy_mask);
    end
    release_arr(3'd3);
    @(negedge clk);
    checks++;
    if (cl_clear_acc !== 1'b1 || cl_array_select !== 3'd3) begin
      failures++;
      $display("FAIL b2b_realloc got clr=%b sel=%0d want 1 3",
               cl_clear_acc, cl_array_select);
    end
    wait_done(100, n);
    checks++;
    if (n < 0) begin
      failures++;
      $display("FAIL b2b_ninth_timeout");
    end else begin
      e = sb.pop_front();
      if ({done_array, done_tag} !== {e.arr, e.tag}) begin
        failures++;
        $display("FAIL b2b_ninth got %0d/%h want %0d/%h",
                 done_array, done_tag, e.arr, e.tag);
      end
      ack();
    end
  endtask

  task automatic test_feed_toggle();
    int beats = 0, bad = 0, scyc = 0, scount = 0, n;
    bit stream = 1'b0;
    exp_t e;
    do_reset();
    push_job(3, 6, 3'd0);
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (stream) begin
        feed_valid = (scyc % 2 == 0);
        scyc++;
      end else begin
        feed_valid = 1'b1;
      end
      #1;
      if (feed_zero) break;
      if (stream) begin
        scount++;
        if (cl_compute_enable) beats++;
        if (cl_compute_enable !== feed_valid) bad++;
      end
      if (cl_load_weights) stream = 1'b1;
    end
    feed_valid = 1'b1;
    checks++;
    if (beats !== 3 || bad !== 0 || scount !== 5) begin
      failures++;
      $display("FAIL toggle_beats got beats=%0d bad=%0d cyc=%0d want 3 0 5",
               beats, bad, scount);
    end
    wait_done(60, n);
    checks++;
    if (n < 0) begin
      failures++;
      $display("FAIL toggle_timeout");
    end else begin
      e = sb.pop_front();
      if ({done_array, done_tag} !== {e.arr, e.tag}) begin
        failures++;
        $display("FAIL toggle_done got %0d/%h want %0d/%h",
                 done_array, done_tag, e.arr, e.tag);
      end
      ack();
    end
  endtask

  task automatic test_k_zero();
    int beats = 0, reqs = 0, done_n = -1, n, stuck = 0;
    exp_t e;
    do_reset();
    push_job(0, 9, 3'd0);
    for (int c = 1; c <= 60 && done_n < 0; c++) begin
      @(negedge clk);
      if (cl_compute_enable && !feed_zero) beats++;
      if (feed_req) reqs++;
      if (done_valid) done_n = c;
    end
    checks++;
    if (beats !== 0 || reqs !== 1) begin
      failures++;
      $display("FAIL kz_stream got beats=%0d req=%0d want 0 1", beats, reqs);
    end
    // LOAD t+4, DRAIN t+5..t+18, WAIT_RDY t+19, REPORT t+20.
    checks++;
    if (done_n !== 20) begin
      failures++;
      $display("FAIL kz_latency got %0d want 20", done_n);
    end
    if (done_n > 0) begin
      e = sb.pop_front();
      checks++;
      if ({done_array, done_tag} !== {e.arr, e.tag}) begin
        failures++;
        $display("FAIL kz_done got %0d/%h want %0d/%h",
                 done_array, done_tag, e.arr, e.tag);
      end
    end
    for (int i = 1; i <= 4; i++) push_job(0, i, 3'(i));
    checks++;
    if (job_ready !== 1'b0) begin
      failures++;
      $display("FAIL kz_full got %b want 0", job_ready);
    end
    @(negedge clk);
    job_valid = 1'b1;
    job_tag   = 4'hF;
    repeat (3) begin
      @(negedge clk);
      if (job_ready) stuck++;
    end
    job_valid = 1'b0;
    checks++;
    if (stuck !== 0) begin
      failures++;
      $display("FAIL kz_fifth got ready cycles=%0d want 0", stuck);
    end
    ack();
    for (int i = 0; i < 4; i++) begin
      wait_done(60, n);
      checks++;
      if (n < 0) begin
        failures++;
        $display("FAIL kz_drain_timeout %0d", i);
      end else begin
        e = sb.pop_front();
        if ({done_array, done_tag} !== {e.arr, e.tag}) begin
          failures++;
          $display("FAIL kz_queued got %0d/%h want %0d/%h",
                   done_array, done_tag, e.arr, e.tag);
        end
        ack();
      end
    end
    wait_done(40, n);
    checks++;
    if (n >= 0) begin
      failures++;
      $display("FAIL kz_extra got done tag %h want none", done_tag);
      ack();
    end
  endtask

  task automatic test_backpressure();
    int n, bad = 0;
    exp_t e;
    do_reset();
    push_job(2, 10, 3'd0);
    push_job(2, 11, 3'd1);
    wait_done(80, n);
    checks++;
    if (n < 0) begin
      failures++;
      $display("FAIL bp_timeout");
    end else begin
      e = sb.pop_front();
      if ({done_array, done_tag} !== {e.arr, e.tag}) begin
        failures++;
        $display("FAIL bp_done got %0d/%h want %0d/%h",
                 done_array, done_tag, e.arr, e.tag);
      end
    end
    // Release a free array, then the one being reported.
    for (int c = 0; c < 10; c++) begin
      release_valid = (c < 2);
      release_array = (c == 0) ? 3'd5 : 3'd0;
      @(negedge clk);
      if (!done_valid || done_array !== 3'd0 ||
          done_tag !== 4'hA || cl_clear_acc) bad++;
    end
    release_valid = 1'b0;
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL bp_stable got bad cycles=%0d want 0", bad);
    end
    checks++;
    if (busy_mask !== 8'h01) begin
      failures++;
      $display("FAIL bp_release got %h want 01", busy_mask);
    end
    ack();
    wait_done(80, n);
    checks++;
    if (n < 0) begin
      failures++;
      $display("FAIL bp_second_timeout");
    end else begin
      e = sb.pop_front();
      if ({done_array, done_tag, busy_mask} !== {e.arr, e.tag, 8'h03}) begin
        failures++;
        $display("FAIL bp_second got %0d/%h busy %h want %0d/%h busy 03",
                 done_array, done_tag, busy_mask, e.arr, e.tag);
      end
      ack();
    end
  endtask

  task automatic test_reset_mid();
    int n, act = 0;
    bit seen = 1'b0;
    exp_t e;
    do_reset();
    push_job(20, 3, 3'd0);
    push_job(5, 4, 3'd1);
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (cl_compute_enable && !feed_zero) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL mid_no_stream");
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({cl_enable, cl_clear_acc, cl_load_weights, cl_compute_enable,
         feed_req, feed_zero, done_valid} !== 7'h00 ||
        busy_mask !== 8'h00 || job_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset got en=%b ce=%b busy=%h rdy=%b want 0 0 00 1",
               cl_enable, cl_compute_enable, busy_mask, job_ready);
    end
    reset = 1'b0;
    sb.delete();
    repeat (5) begin
      @(negedge clk);
      if (cl_enable) act++;
    end
    checks++;
    if (act !== 0) begin
      failures++;
      $display("FAIL mid_flush got active cycles=%0d want 0", act);
    end
    push_job(1, 7, 3'd0);
    wait_done(60, n);
    checks++;
    if (n < 0) begin
      failures++;
      $display("FAIL mid_after_timeout");
    end else begin
      e = sb.pop_front();
      if ({done_array, done_tag} !== {e.arr, e.tag}) begin
        failures++;
        $display("FAIL mid_after got %0d/%h want %0d/%h",
                 done_array, done_tag, e.arr, e.tag);
      end
      ack();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_feed_toggle();
    test_k_zero();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
